tx_arbiter: RTL and testbench

Two-requester scheduler that shares the single UART `tx` line between the command transmitter (source 0, Comunicaciones) and the data transmitter (source 1, EnviarDatos). It replaces the ad-hoc `start_datos`-driven 2:1 mux in the top level. Each source requests the line, receives an exclusive grant for one whole frame, and signals completion. Grants are round-robin, a guard gap holds the line idle between frames, and a watchdog reclaims the line from a hung source.

---
 rtl/tx_arb_pkg.sv | 29 ++
 rtl/tx_arbiter_if.sv | 20 ++
 rtl/tx_arbiter.sv | 108 ++++++++++
 tb/tb_tx_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared definitions for the UART tx-line arbiter: FSM encoding, source ids,
// default guard/timeout derived from the system clock and baud rate.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_e;

    localparam int SRC_CMD  = 0;
    localparam int SRC_DATA = 1;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD   = 9600;

    // One bit time of idle line between frames; the timeout (12 ms) is far
    // longer than any legitimate frame so it only fires on a hung source.
    localparam int unsigned DEF_GUARD_CYCLES = CLK_HZ / BAUD;
    localparam int unsigned DEF_TIMEOUT      = (CLK_HZ / 1000) * 12;

    function automatic int cnt_width(input int timeout, input int guard);
        int m;
        m = (timeout > guard) ? timeout : guard;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Request/grant/serial bundle between the two UART sources and the arbiter.
interface tx_arbiter_if;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] tx_in;
    logic [1:0] grant;
    logic       tx;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  req, done, tx_in,
        output grant, tx, busy, timeout_err
    );

    modport master (
        output req, done, tx_in,
        input  grant, tx, busy, timeout_err
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin owner of the shared UART tx line: one frame per grant, a guard
// gap after every grant, and a watchdog that reclaims the line from a hung source.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    tx_arbiter_if.slave  bus
);

    localparam int CW = cnt_width(int'(TIMEOUT), int'(GUARD_CYCLES));

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] GRANT = ST_GRANT;
    localparam logic [1:0] GUARD = ST_GUARD;

    localparam logic [CW-1:0] TO_LOAD    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          tx_q, tx_d;
    logic          terr_q, terr_d;

    logic          winner;
    logic          own_done;
    logic          own_req;

    // On contention the source that was not served last wins.
    assign winner   = (bus.req == 2'b11) ? ~last_q : bus.req[SRC_DATA];
    assign own_done = bus.done[owner_q];
    assign own_req  = bus.req[owner_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        tx_d    = 1'b1;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d = winner;
                    state_d = GRANT;
                    cnt_d   = TO_LOAD;
                end
            end
            GRANT: begin
                tx_d = bus.tx_in[owner_q];
                // Completion outranks both abort and timeout.
                if (own_done || !own_req || (cnt_q == '0)) begin
                    terr_d  = !own_done && own_req;
                    last_d  = owner_q;
                    state_d = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                    cnt_d   = GUARD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            tx_q    <= 1'b1;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            tx_q    <= tx_d;
            terr_q  <= terr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign bus.grant[gi] = (state_q == GRANT) && (owner_q == 1'(gi));
        end
    endgenerate

    assign bus.tx          = tx_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed and random stimulus for tx_arbiter, checked every cycle against a
// cycle-count model of ownership, guard gap and watchdog.
module tb_tx_arbiter;
    localparam int GC = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst;
    int   vec_count   = 0;
    int   miscompares = 0;

    tx_arbiter_if bus();

    tx_arbiter #(.GUARD_CYCLES(GC), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: owner (-1 = none), edges held so far, guard cycles remaining.
    int   m_owner, m_held, m_guard, m_last;
    logic m_tx, m_terr;

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_guard = 0; m_last = 1;
        m_tx = 1'b1; m_terr = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic [1:0] d, input logic [1:0] t);
        logic nx_tx, nx_terr;
        nx_tx = 1'b1; nx_terr = 1'b0;
        if (m_owner >= 0) begin
            nx_tx = t[m_owner];
            m_held++;
            if (d[m_owner] || !r[m_owner] || m_held == TO) begin
                nx_terr = !d[m_owner] && r[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_guard = GC;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else if (r != 2'b00) begin
            m_owner = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
            m_held  = 0;
        end
        m_tx = nx_tx; m_terr = nx_terr;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        check("grant", 32'(bus.grant), 32'(eg));
        check("tx", 32'(bus.tx), 32'(m_tx));
        check("busy", 32'(bus.busy), 32'((m_owner >= 0) || (m_guard > 0)));
        check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    endtask

    task automatic step(input logic [1:0] r, input logic [1:0] d, input logic [1:0] t);
        bus.req = r; bus.done = d; bus.tx_in = t;
        @(posedge clk); #1;
        if (!rst) model_reset();
        else      model_edge(r, d, t);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            step(2'b00, 2'b00, 2'b11);
            n++;
        end
        check("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    logic [1:0] rr;
    int waited, held, pulses, glen;

    initial begin
        rst = 1'b0;
        bus.req = 2'b00; bus.done = 2'b00; bus.tx_in = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Round robin from reset: 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (bus.grant == 2'b00 && waited < 20) begin
                step(2'b11, 2'b00, 2'b11);
                waited++;
            end
            check("rr_order", 32'(bus.grant), (k % 2) ? 32'd2 : 32'd1);
            repeat (3) step(2'b11, 2'b00, 2'($urandom));
            step(2'b11, bus.grant, 2'b11);
        end

        // Single request with guard length measured
        wait_idle();
        step(2'b01, 2'b00, 2'b11);
        check("single_grant", 32'(bus.grant), 32'd1);
        for (int i = 0; i < 7; i++) step(2'b01, 2'b00, 2'($urandom));
        step(2'b01, 2'b01, 2'b10);
        check("done_drop", 32'(bus.grant), 32'd0);
        glen = 0;
        while (bus.busy && glen < 20) begin
            step(2'b00, 2'b00, 2'b00);
            glen++;
        end
        check("guard_len", 32'(glen), 32'(GC));

        // Watchdog on source 1
        wait_idle();
        waited = 0;
        while (bus.grant == 2'b00 && waited < 20) begin
            step(2'b10, 2'b00, 2'b11);
            waited++;
        end
        held = 0; pulses = 0;
        while (bus.grant != 2'b00 && held < 40) begin
            step(2'b10, 2'b00, 2'($urandom));
            held++;
            if (bus.timeout_err) pulses++;
        end
        check("timeout_len", 32'(held), 32'(TO));
        check("timeout_pulses", 32'(pulses), 32'd1);
        waited = 0;
        while (bus.grant == 2'b00 && waited < 20) begin
            step(2'b11, 2'b00, 2'b11);
            waited++;
        end
        check("after_timeout", 32'(bus.grant), 32'd1);

        // done coinciding with watchdog expiry, plus a stray done[1]
        wait_idle();
        step(2'b01, 2'b00, 2'b11);
        for (int i = 0; i < TO - 1; i++)
            step(2'b01, (i == 3) ? 2'b10 : 2'b00, 2'($urandom));
        step(2'b01, 2'b01, 2'b11);
        check("coincide_grant", 32'(bus.grant), 32'd0);
        check("coincide_err", 32'(bus.timeout_err), 32'd0);

        // Abort by dropping req
        wait_idle();
        step(2'b01, 2'b00, 2'b11);
        repeat (3) step(2'b01, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b01);
        check("abort_grant", 32'(bus.grant), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd1);
        check("abort_err", 32'(bus.timeout_err), 32'd0);

        // Asynchronous reset mid-frame while the owner drives 0
        wait_idle();
        step(2'b01, 2'b00, 2'b11);
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        check("pre_reset_tx", 32'(bus.tx), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        step(2'b11, 2'b00, 2'b00);
        rst = 1'b1;
        step(2'b11, 2'b00, 2'b11);
        check("post_reset_rr", 32'(bus.grant), 32'd1);

        // Random traffic with sticky requests
        rr = 2'b00;
        for (int i = 0; i < 500; i++) begin
            logic [1:0] d;
            if ($urandom_range(0, 5) == 0) rr = 2'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(rr, d, 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
